// File: rtl/idelay_sweep_ctrl_if.sv
// Signal bundle between host/capture logic and the IDELAYE2 tap sweep controller.
// The host/capture side uses modport master and the controller uses modport slave.
interface idelay_sweep_ctrl_if #(
    parameter int TAP_W = 5
);
    logic             dly_rdy;
    logic             start;
    logic             abort;
    logic [TAP_W-1:0] tap_first;
    logic [TAP_W-1:0] tap_last;
    logic [TAP_W-1:0] tap_step;
    logic             smp_ack;
    logic [TAP_W-1:0] idly_cntvalue;
    logic             idly_ld;
    logic             idly_ldpipeen;
    logic             smp_req;
    logic [TAP_W-1:0] cur_tap;
    logic             busy;
    logic             done;

    modport master (
        output dly_rdy, start, abort, tap_first, tap_last, tap_step, smp_ack,
        input  idly_cntvalue, idly_ld, idly_ldpipeen, smp_req, cur_tap, busy, done
    );

    modport slave (
        input  dly_rdy, start, abort, tap_first, tap_last, tap_step, smp_ack,
        output idly_cntvalue, idly_ld, idly_ldpipeen, smp_req, cur_tap, busy, done
    );
endinterface

// File: rtl/idelay_sweep_ctrl.sv
// Steps one variable-load IDELAYE2 across a tap range, one sample handshake per tap.
// Define IDELAY_PIPE_LOAD_EN to preload through LDPIPEEN one cycle before every LD.
module idelay_sweep_ctrl #(
    parameter int TAP_W         = 5,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic               clk_in,
    input  logic               rst_n,
    idelay_sweep_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, PIPE, LOAD, SETTLE, SAMPLE, NEXT, DONE
    } state_t;

`ifdef IDELAY_PIPE_LOAD_EN
    localparam state_t LOAD_ENTRY = PIPE;
`else
    localparam state_t LOAD_ENTRY = LOAD;
`endif

    // Counter holds remaining settle cycles minus one, so SAMPLE begins SETTLE_CYCLES after LOAD.
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_ONE     = {{(TAP_W-1){1'b0}}, 1'b1};
    localparam logic [TAP_W-1:0] TAP_ZERO    = {TAP_W{1'b0}};

    state_t           state_q;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] last_q;
    logic [TAP_W-1:0] step_q;
    logic             desc_q;
    logic [7:0]       cnt_q;
    logic [TAP_W-1:0] cntvalue_q;
    logic             ld_q;
    logic             ldpipe_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;

    logic [TAP_W:0]   sum_s;
    logic [TAP_W:0]   diff_s;
    logic [TAP_W-1:0] next_tap_d;

    // Next tap: one extra bit catches wrap past either end, clamped onto the last tap.
    always_comb begin
        sum_s  = {1'b0, tap_q} + {1'b0, step_q};
        diff_s = {1'b0, tap_q} - {1'b0, step_q};
        if (desc_q) begin
            if (diff_s[TAP_W] || (diff_s < {1'b0, last_q})) begin
                next_tap_d = last_q;
            end else begin
                next_tap_d = diff_s[TAP_W-1:0];
            end
        end else begin
            if (sum_s > {1'b0, last_q}) begin
                next_tap_d = last_q;
            end else begin
                next_tap_d = sum_s[TAP_W-1:0];
            end
        end
    end

    // Sweep sequencer with registered delay-line, handshake and status outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tap_q      <= TAP_ZERO;
            last_q     <= TAP_ZERO;
            step_q     <= TAP_ONE;
            desc_q     <= 1'b0;
            cnt_q      <= 8'd0;
            cntvalue_q <= TAP_ZERO;
            ld_q       <= 1'b0;
            ldpipe_q   <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ld_q     <= 1'b0;
            ldpipe_q <= 1'b0;
            done_q   <= 1'b0;
            if (bus.abort) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            tap_q   <= bus.tap_first;
                            last_q  <= bus.tap_last;
                            step_q  <= (bus.tap_step == TAP_ZERO) ? TAP_ONE : bus.tap_step;
                            desc_q  <= (bus.tap_first > bus.tap_last);
                            busy_q  <= 1'b1;
                            state_q <= WAIT_RDY;
                        end
                    end
                    WAIT_RDY: begin
                        if (bus.dly_rdy) begin
                            cntvalue_q <= tap_q;
                            ld_q       <= (LOAD_ENTRY == LOAD);
                            ldpipe_q   <= (LOAD_ENTRY == PIPE);
                            state_q    <= LOAD_ENTRY;
                        end
                    end
                    PIPE: begin
                        if (!bus.dly_rdy) begin
                            state_q <= WAIT_RDY;
                        end else begin
                            ld_q    <= 1'b1;
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (!bus.dly_rdy) begin
                            state_q <= WAIT_RDY;
                        end else begin
                            cnt_q   <= SETTLE_INIT;
                            state_q <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (!bus.dly_rdy) begin
                            state_q <= WAIT_RDY;
                        end else if (cnt_q == 8'd0) begin
                            req_q   <= 1'b1;
                            state_q <= SAMPLE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    SAMPLE: begin
                        if (bus.smp_ack) begin
                            req_q   <= 1'b0;
                            state_q <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (tap_q == last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // Advance even when ready is lost; WAIT_RDY then loads the new tap.
                            tap_q <= next_tap_d;
                            if (bus.dly_rdy) begin
                                cntvalue_q <= next_tap_d;
                                ld_q       <= (LOAD_ENTRY == LOAD);
                                ldpipe_q   <= (LOAD_ENTRY == PIPE);
                                state_q    <= LOAD_ENTRY;
                            end else begin
                                state_q <= WAIT_RDY;
                            end
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.idly_cntvalue = cntvalue_q;
    assign bus.cur_tap       = cntvalue_q;
    assign bus.idly_ld       = ld_q;
    assign bus.idly_ldpipeen = ldpipe_q;
    assign bus.smp_req       = req_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
// Directed bench for idelay_sweep_ctrl: table of sweeps plus reset, abort and ready-loss sequences.
module tb_idelay_sweep_ctrl;
    localparam int TAP_W  = 5;
    localparam int SETTLE = 8;
`ifdef IDELAY_PIPE_LOAD_EN
    localparam int PIPE_EXTRA = 1;
`else
    localparam int PIPE_EXTRA = 0;
`endif
    localparam int TAP_COST = 1 + SETTLE + 1 + 1 + PIPE_EXTRA;

    logic clk_in = 1'b0;
    logic rst_n;
    always #5 clk_in = ~clk_in;

    idelay_sweep_ctrl_if #(.TAP_W(TAP_W)) bus ();

    idelay_sweep_ctrl #(.TAP_W(TAP_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  first;
        logic [4:0]  last;
        logic [4:0]  step;
        int          ack_mode;
        int          drop_tap;
        int          n_smp;
        int          n_ld;
        logic [39:0] taps;
    } vec_t;

    vec_t vecs[9];
    int   checks   = 0;
    int   failures = 0;
    int   pipe_err = 0;
    logic prev_pipe = 1'b0;

    function automatic logic [39:0] pack8(input int t0, t1, t2, t3, t4, t5, t6, t7);
        pack8 = {5'(t7), 5'(t6), 5'(t5), 5'(t4), 5'(t3), 5'(t2), 5'(t1), 5'(t0)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Load-strobe pairing: LDPIPEEN must lead LD by one cycle, or never appear without the option.
    always @(negedge clk_in) begin
`ifdef IDELAY_PIPE_LOAD_EN
        if (bus.idly_ld && !prev_pipe) pipe_err++;
        if (prev_pipe && !bus.idly_ld) pipe_err++;
`else
        if (bus.idly_ldpipeen) pipe_err++;
`endif
        prev_pipe = bus.idly_ldpipeen;
    end

    task automatic run_vec(input vec_t v, input int idx);
        int   n_smp, n_ld, n_done, n_reld;
        int   first_ld, first_req, last_req, done_cyc, drop_cnt;
        bit   dropped, finished;
        int   smp_taps[16];
        n_smp = 0; n_ld = 0; n_done = 0; n_reld = 0;
        first_ld = -1; first_req = -1; last_req = -1; done_cyc = -1; drop_cnt = 0;
        dropped = 1'b0; finished = 1'b0;
        for (int i = 0; i < 16; i++) smp_taps[i] = -1;

        bus.tap_first = v.first;
        bus.tap_last  = v.last;
        bus.tap_step  = v.step;
        bus.start     = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.smp_ack = (v.ack_mode == 1);
        chk($sformatf("v%0d_busy_after_start", idx), int'(bus.busy), 1);

        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (v.ack_mode == 0) bus.smp_ack = 1'b0;
            if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 10) bus.dly_rdy = 1'b0;
                if (drop_cnt == 0)  bus.dly_rdy = 1'b1;
            end
            if (bus.idly_ld) begin
                n_ld++;
                if (first_ld < 0) first_ld = cyc;
                if (int'(bus.idly_cntvalue) == v.drop_tap) begin
                    n_reld++;
                    if (!dropped) begin
                        dropped  = 1'b1;
                        drop_cnt = 13;
                    end
                end
            end
            if (bus.smp_req) begin
                if (first_req < 0) first_req = cyc;
                last_req = cyc;
                if (n_smp < 16) smp_taps[n_smp] = int'(bus.cur_tap);
                n_smp++;
                if (v.ack_mode == 0) bus.smp_ack = 1'b1;
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
                finished = 1'b1;
            end
            if (finished) break;
        end
        bus.smp_ack = 1'b0;
        tick();
        chk($sformatf("v%0d_done_pulse_len", idx), int'(bus.done), 0);
        chk($sformatf("v%0d_busy_after_done", idx), int'(bus.busy), 0);
        chk($sformatf("v%0d_done_count", idx), n_done, 1);
        chk($sformatf("v%0d_n_samples", idx), n_smp, v.n_smp);
        chk($sformatf("v%0d_n_loads", idx), n_ld, v.n_ld);
        for (int i = 0; i < v.n_smp; i++) begin
            chk($sformatf("v%0d_tap%0d", idx, i), smp_taps[i], int'(v.taps[i*5 +: 5]));
        end
        chk($sformatf("v%0d_first_ld_cycle", idx), first_ld, PIPE_EXTRA);
        chk($sformatf("v%0d_ld_to_req", idx), first_req - first_ld, SETTLE + 1);
        chk($sformatf("v%0d_req_to_done", idx), done_cyc - last_req, 2);
        if (v.drop_tap >= 0) begin
            chk($sformatf("v%0d_reload_count", idx), n_reld, 2);
        end else begin
            chk($sformatf("v%0d_sweep_length", idx), done_cyc,
                first_ld + (v.n_smp - 1) * TAP_COST + SETTLE + 1 + 2);
        end
        tick();
    endtask

    task automatic wait_req(input string name);
        for (int k = 0; k < 60; k++) begin
            if (bus.smp_req) break;
            tick();
        end
        chk(name, int'(bus.smp_req), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},     int'(bus.busy), 0);
        chk({tag, "_done"},     int'(bus.done), 0);
        chk({tag, "_smp_req"},  int'(bus.smp_req), 0);
        chk({tag, "_ld"},       int'(bus.idly_ld), 0);
        chk({tag, "_ldpipe"},   int'(bus.idly_ldpipeen), 0);
        chk({tag, "_cntvalue"}, int'(bus.idly_cntvalue), 0);
        chk({tag, "_cur_tap"},  int'(bus.cur_tap), 0);
    endtask

    initial begin
        int n_act, n_high;
        vecs[0] = '{5'd0,  5'd31, 5'd8,  0, -1, 5, 5, pack8(0, 8, 16, 24, 31, 0, 0, 0)};
        vecs[1] = '{5'd5,  5'd2,  5'd0,  0, -1, 4, 4, pack8(5, 4, 3, 2, 0, 0, 0, 0)};
        vecs[2] = '{5'd31, 5'd0,  5'd10, 0, -1, 5, 5, pack8(31, 21, 11, 1, 0, 0, 0, 0)};
        vecs[3] = '{5'd7,  5'd7,  5'd3,  0, -1, 1, 1, pack8(7, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4] = '{5'd30, 5'd31, 5'd5,  0, -1, 2, 2, pack8(30, 31, 0, 0, 0, 0, 0, 0)};
        vecs[5] = '{5'd2,  5'd9,  5'd3,  0, -1, 4, 4, pack8(2, 5, 8, 9, 0, 0, 0, 0)};
        vecs[6] = '{5'd3,  5'd0,  5'd2,  1, -1, 3, 3, pack8(3, 1, 0, 0, 0, 0, 0, 0)};
        vecs[7] = '{5'd0,  5'd31, 5'd8,  0,  8, 5, 6, pack8(0, 8, 16, 24, 31, 0, 0, 0)};
        vecs[8] = '{5'd0,  5'd31, 5'd31, 0, -1, 2, 2, pack8(0, 31, 0, 0, 0, 0, 0, 0)};

        rst_n = 1'b0;
        bus.dly_rdy = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.smp_ack = 1'b0;
        bus.tap_first = 5'd0; bus.tap_last = 5'd0; bus.tap_step = 5'd0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset in the middle of SETTLE.
        bus.tap_first = 5'd0; bus.tap_last = 5'd31; bus.tap_step = 5'd8;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.idly_ld) break;
            tick();
        end
        chk("rst_mid_saw_ld", int'(bus.idly_ld), 1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick(); tick();
        check_idle_outputs("rst_mid");
        rst_n = 1'b1;
        n_act = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_act += int'(bus.busy) + int'(bus.done) + int'(bus.idly_ld) + int'(bus.smp_req);
        end
        chk("rst_mid_stays_idle", n_act, 0);

        // Backpressure on tap 8, ignored start while busy, then abort.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_req("abort_req0");
        chk("abort_tap0", int'(bus.cur_tap), 0);
        bus.smp_ack = 1'b1;
        tick();
        bus.smp_ack = 1'b0;
        wait_req("abort_req1");
        chk("abort_tap1", int'(bus.cur_tap), 8);
        n_high = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                bus.tap_first = 5'd20; bus.tap_last = 5'd25; bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            n_high += int'(bus.smp_req);
        end
        chk("backpressure_req_held", n_high, 20);
        chk("busy_start_ignored_tap", int'(bus.cur_tap), 8);
        chk("busy_start_ignored_busy", int'(bus.busy), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_smp_req", int'(bus.smp_req), 0);
        chk("abort_ld", int'(bus.idly_ld), 0);
        chk("abort_cur_tap_held", int'(bus.cur_tap), 8);
        n_act = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_act += int'(bus.busy) + int'(bus.done) + int'(bus.idly_ld);
        end
        chk("abort_no_done", n_act, 0);

        // Start and abort together while idle.
        bus.tap_first = 5'd4; bus.tap_last = 5'd6; bus.tap_step = 5'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("start_abort_busy", int'(bus.busy), 0);
        n_act = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_act += int'(bus.busy) + int'(bus.idly_ld);
        end
        chk("start_abort_idle", n_act, 0);

        chk("ldpipeen_pairing", pipe_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
